// File: rtl/dct2d_seq.sv
// dct2d_seq: control sequencer for a 2-D DCT chain built as
//   row-DCT -> 8x8 transpose memory -> column-DCT.
// One lockstep advance enable (ce) drives both 1-D DCT pipelines and the
// transpose memory enable, so the three stages always move together. A
// valid-token shift register, as deep as the whole chain, tracks which
// pipeline slots carry real samples. At the end of a stream, the last block
// is pushed out by injecting zero bubbles.
//
// Handshake: a transfer happens on a cycle where valid and ready are both
// high. Upstream: a sample is taken when in_valid & in_ready. Downstream: a
// coefficient is consumed when out_valid & out_ready and the chain advances
// (ce). out_valid stays high while the chain is stalled waiting for input.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid / in_ready     upstream sample handshake
//   flush                   pulse: drain the chain after the current block
//   abort                   synchronous clear of the whole chain
//   out_ready / out_valid   downstream coefficient handshake
//   out_sop / out_eop       first / last coefficient of an output block
//   ce, tm_enb              advance enable for DCT stages / transpose memory
//   tm_rst                  transpose memory synchronous clear
//   bubble                  row-DCT input selects zero (flush filler)
//   in_row, in_col          position of the next sample to be accepted
//   blk_in_cnt, blk_out_cnt blocks fully accepted / emitted (wrapping)
//   busy                    sequencer not idle
//   dbg_state               current FSM state
module dct2d_seq #(
  parameter int ROW_LAT = 2,
  parameter int COL_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic             abort,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic             ce,
  output logic             tm_enb,
  output logic             tm_rst,
  output logic             bubble,
  output logic [2:0]       in_row,
  output logic [2:0]       in_col,
  output logic [CNT_W-1:0] blk_in_cnt,
  output logic [CNT_W-1:0] blk_out_cnt,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Token latency through row stage, transpose memory and column stage.
  localparam int L  = ROW_LAT + 64 + COL_LAT;
  localparam int DW = $clog2(L + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state;
  logic [L-1:0]    vpipe;
  logic            flush_pend;
  logic [5:0]      in_idx;
  logic [5:0]      out_idx;
  logic [DW-1:0]   drain_cnt;

  logic            sink_ok;
  logic            accept;
  logic            xfer;
  logic            go_flush;
  logic [5:0]      in_idx_nxt;

  assign sink_ok    = out_ready | ~out_valid;
  assign in_ready   = (state != FLUSH) & sink_ok & ~tm_rst;
  assign accept     = in_valid & in_ready;
  // While flushing the chain advances whenever the sink can take data;
  // otherwise it advances only on a real sample so no bubble is inserted.
  assign ce         = ~tm_rst & ((state == FLUSH) ? sink_ok : accept);
  assign tm_enb     = ce;
  assign bubble     = (state == FLUSH);
  assign out_valid  = vpipe[L-1];
  assign xfer       = out_valid & out_ready & ce;
  assign out_sop    = out_valid & (out_idx == 6'd0);
  assign out_eop    = out_valid & (out_idx == 6'd63);
  assign in_row     = in_idx[5:3];
  assign in_col     = in_idx[2:0];
  assign busy       = (state != IDLE);
  assign dbg_state  = state;

  // Flush may only start on a block boundary: the input index after this
  // cycle must be 0. This also covers a flush arriving together with the
  // index-63 accept, and a flush in an empty block.
  assign in_idx_nxt = in_idx + {5'd0, accept};
  assign go_flush   = (flush_pend | flush) & (in_idx_nxt == 6'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tm_rst      <= 1'b1;
      vpipe       <= '0;
      flush_pend  <= 1'b0;
      in_idx      <= 6'd0;
      out_idx     <= 6'd0;
      blk_in_cnt  <= '0;
      blk_out_cnt <= '0;
      drain_cnt   <= '0;
    end else begin
      // tm_rst clears the transpose memory on the edge after reset release
      // and on the edge after an abort.
      tm_rst <= abort;
      if (abort) begin
        state       <= IDLE;
        vpipe       <= '0;
        flush_pend  <= 1'b0;
        in_idx      <= 6'd0;
        out_idx     <= 6'd0;
        blk_in_cnt  <= '0;
        blk_out_cnt <= '0;
        drain_cnt   <= '0;
      end else begin
        if (ce)
          vpipe <= {vpipe[L-2:0], (state != FLUSH)};

        if (accept) begin
          in_idx <= in_idx + 6'd1;
          if (in_idx == 6'd63)
            blk_in_cnt <= blk_in_cnt + CNT_W'(1);
        end

        if (xfer) begin
          out_idx <= out_idx + 6'd1;
          if (out_idx == 6'd63)
            blk_out_cnt <= blk_out_cnt + CNT_W'(1);
        end

        case (state)
          IDLE, RUN: begin
            if (go_flush) begin
              state      <= FLUSH;
              drain_cnt  <= DW'(L);
              flush_pend <= 1'b0;
            end else begin
              if (accept)
                state <= RUN;
              if (flush)
                flush_pend <= 1'b1;
            end
          end
          FLUSH: begin
            // flush requests are ignored while draining
            if (ce) begin
              drain_cnt <= drain_cnt - DW'(1);
              if (drain_cnt == DW'(1))
                state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
